// File: rtl/bram_job_sequencer_if.sv
// Descriptor push, BRAM monitor and adapter-config bundle for bram_job_sequencer.
// The master drives descriptors and BRAM activity; the slave is the sequencer.
interface bram_job_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              job_valid;
    logic              job_ready;
    logic              job_rw;
    logic [ADDR_W-1:0] job_start;
    logic [ADDR_W-1:0] job_end;
    logic              abort;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic              cfg_rw;
    logic              cfg_reload;
    logic [ADDR_W-1:0] cfg_start_addr;
    logic [ADDR_W-1:0] cfg_end_addr;
    logic              busy;
    logic [CNT_W-1:0]  jobs_pending;
    logic              done_pulse;
    logic              err_pulse;

    modport master (
        output job_valid, job_rw, job_start, job_end, abort, bram_en, bram_addr,
        input  job_ready, cfg_rw, cfg_reload, cfg_start_addr, cfg_end_addr,
               busy, jobs_pending, done_pulse, err_pulse
    );

    modport slave (
        input  job_valid, job_rw, job_start, job_end, abort, bram_en, bram_addr,
        output job_ready, cfg_rw, cfg_reload, cfg_start_addr, cfg_end_addr,
               busy, jobs_pending, done_pulse, err_pulse
    );
endinterface

// File: rtl/bram_job_sequencer.sv
// Queues BRAM transfer descriptors and hands them one at a time to a stream/BRAM
// adapter, watching its BRAM port for the end address or a stalled transfer.
//
// state | meaning
// IDLE  | no active job; loads FIFO head when one is queued
// LOAD  | cfg_* just loaded from head, cfg_reload high
// RUN   | adapter working; watchdog counts cycles without bram_en
// DONE  | end address seen; done_pulse high, head popped on exit
// ERR   | watchdog expired; err_pulse high, head popped on exit
module bram_job_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic                 s00_axis_aclk,
    input logic                 s00_axis_aresetn,
    bram_job_sequencer_if.slave jif
);
    // DEPTH must be a power of two >= 2 so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              cfg_rw_q;
    logic              cfg_reload_q;
    logic [ADDR_W-1:0] cfg_start_q;
    logic [ADDR_W-1:0] cfg_end_q;
    logic              done_q;
    logic              err_q;

    logic              fifo_rw_q    [DEPTH];
    logic [ADDR_W-1:0] fifo_start_q [DEPTH];
    logic [ADDR_W-1:0] fifo_end_q   [DEPTH];

    logic job_ready_c;
    logic push_acc;
    logic push_ok;
    logic push_bad;
    logic pop;
    logic end_hit;
    logic wd_expire;

    // Ready looks only at the registered count, so a pop in the same cycle never frees a slot.
    always_comb begin
        job_ready_c = s00_axis_aresetn && (count_q < CNT_W'(DEPTH)) && !jif.abort;
        push_acc    = jif.job_valid && job_ready_c;
        push_ok     = push_acc && (jif.job_end >= jif.job_start);
        push_bad    = push_acc && (jif.job_end < jif.job_start);
        pop         = (state_q == S_DONE) || (state_q == S_ERR);
        end_hit     = jif.bram_en && (jif.bram_addr == cfg_end_q);
        wd_expire   = (wdog_q == WD_W'(TIMEOUT));

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        wdog_d = wdog_q;
        if (state_q == S_IDLE || state_q == S_LOAD) begin
            wdog_d = '0;
        end else if (state_q == S_RUN) begin
            if (jif.bram_en) begin
                wdog_d = '0;
            end else if (!wd_expire) begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end
    end

    // Descriptor storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge s00_axis_aclk) begin
        if (push_ok) begin
            fifo_rw_q[wr_ptr_q]    <= jif.job_rw;
            fifo_start_q[wr_ptr_q] <= jif.job_start;
            fifo_end_q[wr_ptr_q]   <= jif.job_end;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wdog_q       <= '0;
            cfg_rw_q     <= 1'b0;
            cfg_reload_q <= 1'b0;
            cfg_start_q  <= '0;
            cfg_end_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (jif.abort) begin
            // Flush keeps cfg_* so the adapter still sees its last configuration.
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wdog_q       <= '0;
            cfg_reload_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wdog_q       <= wdog_d;
            cfg_reload_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= push_bad;

            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q      <= S_LOAD;
                        cfg_rw_q     <= fifo_rw_q[rd_ptr_q];
                        cfg_start_q  <= fifo_start_q[rd_ptr_q];
                        cfg_end_q    <= fifo_end_q[rd_ptr_q];
                        cfg_reload_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // End match wins over an expired watchdog on the same edge.
                    if (end_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (wd_expire) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE,
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign jif.job_ready      = job_ready_c;
    assign jif.cfg_rw         = cfg_rw_q;
    assign jif.cfg_reload     = cfg_reload_q;
    assign jif.cfg_start_addr = cfg_start_q;
    assign jif.cfg_end_addr   = cfg_end_q;
    assign jif.busy           = (state_q != S_IDLE);
    assign jif.jobs_pending   = count_q;
    assign jif.done_pulse     = done_q;
    assign jif.err_pulse      = err_q;
endmodule

// File: tb/tb_bram_job_sequencer.sv
// Directed bench for bram_job_sequencer: stimulus queues expected reloads and
// completions, a forked monitor pops and compares them as the DUT produces them.
module tb_bram_job_sequencer;
    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1024;
    localparam int ERR_LAT = TIMEOUT + 2;   // reload cycle -> err_pulse cycle

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_job_sequencer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bif ();

    bram_job_sequencer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .jif             (bif)
    );

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] e;
    } cfg_t;

    typedef struct packed {
        logic is_err;
        int   lat;
    } cmp_t;

    cfg_t rq[$];
    cmp_t cq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last_reload_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_cfg(input logic rw, input int s, input int e);
        cfg_t c;
        c.rw = rw;
        c.s  = ADDR_W'(s);
        c.e  = ADDR_W'(e);
        rq.push_back(c);
    endtask

    task automatic expect_cmp(input logic is_err, input int lat);
        cmp_t k;
        k.is_err = is_err;
        k.lat    = lat;
        cq.push_back(k);
    endtask

    task automatic monitor();
        cfg_t c;
        cmp_t k;
        forever begin
            @(negedge clk);
            cyc++;
            if (bif.cfg_reload === 1'b1) begin
                last_reload_cyc = cyc;
                if (rq.size() == 0) begin
                    chk("reload_unexpected", 64'(bif.cfg_reload), 64'(0));
                end else begin
                    c = rq.pop_front();
                    chk("reload_cfg", 64'({bif.cfg_rw, bif.cfg_start_addr, bif.cfg_end_addr}), 64'(c));
                end
            end
            if (bif.done_pulse === 1'b1 || bif.err_pulse === 1'b1) begin
                if (cq.size() == 0) begin
                    chk("pulse_unexpected", 64'({bif.done_pulse, bif.err_pulse}), 64'(0));
                end else begin
                    k = cq.pop_front();
                    chk("pulse_kind", 64'({bif.done_pulse, bif.err_pulse}),
                        k.is_err ? 64'(2'b01) : 64'(2'b10));
                    if (k.lat > 0) chk("err_latency", 64'(cyc - last_reload_cyc), 64'(k.lat));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input int s, input int e);
        bif.job_valid = 1'b1;
        bif.job_rw    = rw;
        bif.job_start = ADDR_W'(s);
        bif.job_end   = ADDR_W'(e);
        tick();
        bif.job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!bif.busy && bif.jobs_pending == 0) break;
        end
        chk(name, 64'(n < budget), 64'(1));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(bif.job_ready), 64'(0));
        chk({tag, "_pending"}, 64'(bif.jobs_pending), 64'(0));
        chk({tag, "_busy"}, 64'(bif.busy), 64'(0));
        chk({tag, "_reload"}, 64'(bif.cfg_reload), 64'(0));
        chk({tag, "_cfg"}, 64'({bif.cfg_rw, bif.cfg_start_addr, bif.cfg_end_addr}), 64'(0));
        chk({tag, "_pulses"}, 64'({bif.done_pulse, bif.err_pulse}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic acc;
        bif.job_valid = 1'b0;
        bif.job_rw    = 1'b0;
        bif.job_start = '0;
        bif.job_end   = '0;
        bif.abort     = 1'b0;
        bif.bram_en   = 1'b0;
        bif.bram_addr = '0;
        fork
            monitor();
        join_none

        // Reset values, ready right after release
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(bif.job_ready), 64'(1));

        // Single write job completes on end address 8
        expect_cfg(1'b1, 0, 8);
        expect_cmp(1'b0, 0);
        push(1'b1, 0, 8);
        chk("pending_after_push", 64'(bif.jobs_pending), 64'(1));
        tick();
        chk("load_busy", 64'(bif.busy), 64'(1));
        chk("load_reload", 64'(bif.cfg_reload), 64'(1));
        tick();
        chk("run_reload_low", 64'(bif.cfg_reload), 64'(0));
        for (int a = 0; a <= 8; a++) begin
            bif.bram_en   = 1'b1;
            bif.bram_addr = ADDR_W'(a);
            tick();
        end
        bif.bram_en = 1'b0;
        chk("done_pulse_now", 64'(bif.done_pulse), 64'(1));
        chk("done_pending", 64'(bif.jobs_pending), 64'(1));
        tick();
        chk("after_done_pending", 64'(bif.jobs_pending), 64'(0));
        chk("after_done_busy", 64'(bif.busy), 64'(0));
        chk("cfg_hold", 64'({bif.cfg_rw, bif.cfg_end_addr}), 64'({1'b1, 12'd8}));

        // Reversed range rejected
        expect_cmp(1'b1, 0);
        push(1'b0, 10, 3);
        chk("reject_pending", 64'(bif.jobs_pending), 64'(0));
        chk("reject_err", 64'(bif.err_pulse), 64'(1));
        tick();
        chk("reject_err_one_cycle", 64'(bif.err_pulse), 64'(0));
        chk("reject_busy", 64'(bif.busy), 64'(0));
        repeat (3) tick();

        // Five jobs, FIFO full after four, all expire by watchdog in order
        for (int i = 0; i < 4; i++) begin
            expect_cfg((i % 2) == 1, 16 * i, 16 * i + 4);
            expect_cmp(1'b1, ERR_LAT);
            push((i % 2) == 1, 16 * i, 16 * i + 4);
        end
        chk("full_ready", 64'(bif.job_ready), 64'(0));
        chk("full_pending", 64'(bif.jobs_pending), 64'(4));
        expect_cfg(1'b0, 64, 68);
        expect_cmp(1'b1, ERR_LAT);
        bif.job_valid = 1'b1;
        bif.job_rw    = 1'b0;
        bif.job_start = ADDR_W'(64);
        bif.job_end   = ADDR_W'(68);
        repeat (10) tick();
        chk("fifth_held_pending", 64'(bif.jobs_pending), 64'(4));
        acc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bif.job_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
        end
        bif.job_valid = 1'b0;
        chk("fifth_accepted", 64'(acc), 64'(1));
        wait_idle(6000, "five_jobs_idle");
        chk("five_rq_empty", 64'(rq.size()), 64'(0));
        chk("five_cq_empty", 64'(cq.size()), 64'(0));

        // End match on the edge where the watchdog sits at TIMEOUT
        expect_cfg(1'b0, 100, 105);
        expect_cmp(1'b0, 0);
        push(1'b0, 100, 105);
        tick();
        tick();
        repeat (TIMEOUT) tick();
        chk("at_timeout_busy", 64'(bif.busy), 64'(1));
        chk("at_timeout_no_err", 64'(bif.err_pulse), 64'(0));
        bif.bram_en   = 1'b1;
        bif.bram_addr = ADDR_W'(105);
        tick();
        bif.bram_en = 1'b0;
        chk("tie_takes_done", 64'({bif.done_pulse, bif.err_pulse}), 64'(2'b10));
        wait_idle(10, "tie_idle");

        // Abort during RUN of first of two jobs; push in abort cycle ignored
        expect_cfg(1'b1, 200, 220);
        push(1'b1, 200, 220);
        push(1'b0, 300, 310);
        tick();
        chk("abort_pre_pending", 64'(bif.jobs_pending), 64'(2));
        chk("abort_pre_busy", 64'(bif.busy), 64'(1));
        bif.bram_en   = 1'b1;
        bif.bram_addr = ADDR_W'(201);
        repeat (3) tick();
        bif.bram_en   = 1'b0;
        bif.abort     = 1'b1;
        bif.job_valid = 1'b1;
        bif.job_rw    = 1'b1;
        bif.job_start = ADDR_W'(400);
        bif.job_end   = ADDR_W'(410);
        @(negedge clk);
        chk("abort_ready_low", 64'(bif.job_ready), 64'(0));
        @(posedge clk);
        #1;
        bif.abort     = 1'b0;
        bif.job_valid = 1'b0;
        chk("abort_busy", 64'(bif.busy), 64'(0));
        chk("abort_pending", 64'(bif.jobs_pending), 64'(0));
        chk("abort_pulses", 64'({bif.done_pulse, bif.err_pulse, bif.cfg_reload}), 64'(0));
        chk("abort_cfg_hold", 64'(bif.cfg_start_addr), 64'(200));
        repeat (20) tick();
        chk("abort_after_pending", 64'(bif.jobs_pending), 64'(0));
        chk("abort_after_ready", 64'(bif.job_ready), 64'(1));

        // Reset during RUN with three jobs queued
        expect_cfg(1'b1, 500, 510);
        push(1'b1, 500, 510);
        push(1'b1, 520, 530);
        push(1'b0, 540, 550);
        tick();
        chk("rst_pre_pending", 64'(bif.jobs_pending), 64'(3));
        chk("rst_pre_busy", 64'(bif.busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        rq.delete();
        cq.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int a = 0; a <= 20; a++) begin
            bif.bram_en   = 1'b1;
            bif.bram_addr = ADDR_W'(500 + a);
            tick();
        end
        bif.bram_en = 1'b0;
        repeat (2) tick();
        chk("post_rst_busy", 64'(bif.busy), 64'(0));
        chk("post_rst_pending", 64'(bif.jobs_pending), 64'(0));

        chk("final_rq_empty", 64'(rq.size()), 64'(0));
        chk("final_cq_empty", 64'(cq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bram_job_sequencer.md
BRAM_JOB_SEQUENCER -- requirements
Module: bram_job_sequencer

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 12, BRAM word-address width.
REQ-002 The block SHALL expose parameter DEPTH, default 4, descriptor FIFO depth (power of 2).
REQ-003 The block SHALL expose parameter TIMEOUT, default 1024, idle cycles in RUN before abort-by-watchdog.
REQ-004 s00_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 s00_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-006 job_valid  in  1  descriptor push request.
REQ-007 job_ready  out  1  descriptor can be accepted this cycle.
REQ-008 job_rw  in  1  1 = stream-to-BRAM write job, 0 = BRAM-to-stream read job.
REQ-009 job_start  in  ADDR_W  first BRAM word address.
REQ-010 job_end  in  ADDR_W  last BRAM word address (inclusive).
REQ-011 abort  in  1  flush all jobs, return to IDLE.
REQ-012 bram_en  in  1  adapter BRAM enable, monitored.
REQ-013 bram_addr  in  ADDR_W  adapter BRAM address, monitored.
REQ-014 cfg_rw  out  1  rw control to adapter.
REQ-015 cfg_reload  out  1  one-cycle reload strobe to adapter.
REQ-016 cfg_start_addr  out  ADDR_W  start address to adapter.
REQ-017 cfg_end_addr  out  ADDR_W  end address to adapter.
REQ-018 busy  out  1  state != IDLE.
REQ-019 jobs_pending  out  clog2(DEPTH)+1  FIFO occupancy, active job included.
REQ-020 done_pulse  out  1  one-cycle job-complete strobe.
REQ-021 err_pulse  out  1  one-cycle strobe: descriptor rejected or watchdog expiry.

Function
REQ-022 Push: descriptor accepted on an edge where job_valid && job_ready; job_ready SHALL equal (jobs_pending < DEPTH) && !abort, from registered count only (a same-cycle pop does not free a slot).
REQ-023 Accepted descriptor with job_end < job_start SHALL NOT be enqueued; err_pulse=1 the following cycle; jobs_pending unchanged.
REQ-024 FSM states SHALL be IDLE, LOAD, RUN, DONE, ERR.
REQ-025 IDLE -> LOAD when FIFO non-empty; on that edge cfg_rw/cfg_start_addr/cfg_end_addr SHALL load from FIFO head and cfg_reload=1 for exactly the LOAD cycle.
REQ-026 Push into empty FIFO on edge E SHALL give cfg_reload=1 in cycle after edge E+1 (LOAD), 0 after edge E+2 (RUN).
REQ-027 LOAD -> RUN unconditionally; watchdog counter cleared on entry.
REQ-028 RUN: watchdog counter SHALL clear on any cycle with bram_en=1 and increment otherwise, saturating.
REQ-029 RUN -> DONE on edge where bram_en=1 && bram_addr==cfg_end_addr; DONE asserts done_pulse=1 for one cycle, pops FIFO head, -> IDLE.
REQ-030 RUN -> ERR when watchdog reaches TIMEOUT with no end match; ERR asserts err_pulse=1 one cycle, pops head, -> IDLE.
REQ-031 End match and watchdog expiry on same edge SHALL take DONE.
REQ-032 cfg_rw/cfg_start_addr/cfg_end_addr SHALL hold their last values outside LOAD (adapter keeps config between jobs).
REQ-033 abort=1 SHALL on the next edge force IDLE, empty FIFO (jobs_pending=0), clear watchdog, cfg_reload=0; no done_pulse/err_pulse caused; a push in the abort cycle is ignored.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH; descriptors issue strictly in push order.
REQ-035 Push during RUN SHALL enqueue without affecting the active job.

Reset
REQ-036 While s00_axis_aresetn=0: state IDLE, FIFO empty, jobs_pending=0, job_ready=0, cfg_rw=0, cfg_reload=0, cfg_start_addr=0, cfg_end_addr=0, busy=0, done_pulse=0, err_pulse=0, watchdog=0.
REQ-037 job_ready SHALL assert the first cycle after reset release; reset mid-job discards all jobs with no pulses.

Verification
REQ-038 Push {rw=1,start=0,end=8} into empty -> cfg_reload one cycle, cfg_rw=1, cfg_end_addr=8; drive bram_en with addr 0..8 -> done_pulse one cycle after addr 8, jobs_pending 1->0, busy=0.
REQ-039 Push 5 valid jobs back-to-back with no BRAM activity -> job_ready=0 after 4th accept, 5th held; jobs issue in order, each ending with err_pulse after 1024 idle RUN cycles.
REQ-040 Push {start=10,end=3} -> err_pulse one cycle, jobs_pending stays 0, no cfg_reload.
REQ-041 Two queued jobs, abort during RUN of first -> next cycle IDLE, jobs_pending=0, no done_pulse/err_pulse, no further cfg_reload.
REQ-042 End match on exactly cycle TIMEOUT -> done_pulse, not err_pulse.
REQ-043 Assert reset during RUN with 3 jobs queued -> all outputs at REQ-036 values immediately; after release, bram_en activity produces no pulses.
